mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the single-cycle-to-multi-cycle MIPS datapath. Sits directly downstream of the instruction fetch unit. Latches the opcode/funct fields of the fetched instruction and sequences each instruction through an FSM. Drives PC update, next-PC selection, register file, ALU, extender and data-memory controls, and keeps a retired-instruction count.

## Interface
Parameters:
- none

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high
- instr  input  32  current fetch-unit instruction word; sampled only in FETCH
- zero  input  1  ALU equality flag; valid in BR state
- ir_wr  output  1  asserted in FETCH; opcode/funct latched at that edge
- pc_wr  output  1  PC update strobe; exactly one cycle per instruction
- npc_sel  output  2  00 pc+4, 01 branch (pc+sext(imm)<<2), 10 jump target, 11 register (jr)
- ext_op  output  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- alu_src  output  1  0 register rt, 1 extended immediate
- alu_op  output  3  000 add, 001 sub, 010 or, 011 pass-B
- reg_dst  output  2  00 rt, 01 rd, 10 $31
- mem_to_reg  output  2  00 ALU, 01 memory, 10 pc+4
- reg_wr  output  1  register file write enable
- mem_wr  output  1  data memory write enable
- illegal  output  1  one-cycle pulse on unsupported encoding
- state  output  4  current FSM state, for debug
- instr_cnt  output  32  retired-instruction counter

## Operation
- Supported instructions:
  - addu: op 000000, funct 100001
  - subu: op 000000, funct 100011
  - ori: 001101
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - lui: 001111
  - j: 000010
- States and encodings: FETCH 0, DECODE 1, MA 2, MR 3, MW 4, WB_MEM 5, EXE 6, WB_ALU 7, BR 8, JMP 9.
- Transitions:
  - FETCH → DECODE always.
  - DECODE → EXE (addu, subu, ori, lui), MA (lw, sw), BR (beq), JMP (j); illegal → FETCH.
  - EXE → WB_ALU → FETCH.
  - MA → MR (lw) or MW (sw).
  - MR → WB_MEM → FETCH.
  - MW, BR, JMP → FETCH.
- Output assertions by state:
  - EXE and WB_ALU: addu alu_op 000, reg_dst 01. subu alu_op 001, reg_dst 01. ori alu_src 1, ext_op 00, alu_op 010, reg_dst 00. lui alu_src 1, ext_op 10, alu_op 011, reg_dst 00.
  - MA/MR/MW/WB_MEM: alu_src 1, ext_op 01, alu_op 000.
  - WB_ALU: reg_wr=1, mem_to_reg 00, pc_wr=1, npc_sel 00.
  - WB_MEM: reg_wr=1, mem_to_reg 01, reg_dst 00, pc_wr=1.
  - MW: mem_wr=1, pc_wr=1, npc_sel 00.
  - BR: alu_op 001, alu_src 0, pc_wr=1, npc_sel = zero ? 01 : 00.
  - JMP: pc_wr=1, npc_sel 10.
  - Illegal in DECODE: illegal=1, pc_wr=1, npc_sel 00; reg_wr and mem_wr stay 0.
- All unlisted outputs are 0 in every state.
- instr_cnt increments by 1 on every edge where pc_wr=1. Wraps 0xFFFFFFFF → 0 silently.

## Timing
- Moore outputs, decoded from state and the latched opcode/funct. Exception: npc_sel in BR follows zero combinationally.
- Cycles per instruction: j/beq 3; addu/subu/ori/lui/sw 4; lw 5; illegal 2.
- instr is ignored outside FETCH. Changes to instr mid-instruction have no effect.
- Reset, asynchronous:
  - state → FETCH.
  - Latched opcode/funct → 0.
  - instr_cnt → 0.
  - All strobes 0 while reset is held.
  - Asserting reset mid-instruction aborts it with no reg_wr/mem_wr/pc_wr.
- First cycle after reset release is FETCH with ir_wr=1.

## Configuration
- CTRL_JAL_EN defined:
  - jal (op 000011): DECODE → JMP. In JMP additionally reg_wr=1, reg_dst 10, mem_to_reg 10; 3 cycles.
  - jr (op 000000, funct 001000): DECODE → JMP with npc_sel 11, no register write; 3 cycles.
- CTRL_JAL_EN undefined: both encodings take the illegal path.

## Test plan
- Reset mid-sequence:
  - Assert reset during MR of lw → state=0, instr_cnt=0, no reg_wr pulse.
  - After release, first cycle ir_wr=1.
- addu 0x00221821 → states 0,1,6,7. In state 7: reg_wr=1, reg_dst=01, pc_wr=1. instr_cnt +1.
- lw 0x8C220004 then sw 0xAC220004:
  - lw visits 0,1,2,3,5 with reg_wr=1, mem_to_reg=01 only in 5.
  - sw visits 0,1,2,4 with mem_wr=1 only in 4.
- beq 0x10220003:
  - With zero=1 → BR npc_sel=01.
  - With zero=0 → npc_sel=00.
  - 3 cycles each.
- Encoding 0xFC000000 → illegal pulse in DECODE, pc_wr=1, reg_wr=mem_wr=0, back to FETCH next cycle.
- With CTRL_JAL_EN, jal 0x0C000C00 → JMP asserts reg_wr=1, reg_dst=10, mem_to_reg=10, npc_sel=10. Without it, the same word raises illegal.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control-unit bundle: fetched instruction and ALU flag in, datapath controls out.
// The controller uses the master view, the datapath the slave view.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  npc_sel;
  logic [1:0]  ext_op;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        reg_wr;
  logic        mem_wr;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  modport master (
    input  instr, zero,
    output ir_wr, pc_wr, npc_sel, ext_op, alu_src, alu_op, reg_dst,
           mem_to_reg, reg_wr, mem_wr, illegal, state, instr_cnt
  );

  modport slave (
    output instr, zero,
    input  ir_wr, pc_wr, npc_sel, ext_op, alu_src, alu_op, reg_dst,
           mem_to_reg, reg_wr, mem_wr, illegal, state, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with registered Moore outputs and a retired-instruction count.
// Optional jal/jr support is enabled by defining CTRL_JAL_EN; otherwise both decode as illegal.
module mc_ctrl (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4,
    WB_MEM = 4'd5, EXE = 4'd6, WB_ALU = 4'd7, BR = 4'd8, JMP = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL, I_JR, I_ILL
  } cls_t;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic [1:0] ext_op;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_wr;
    logic       mem_wr;
    logic       illegal;
  } ctl_t;

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = I_ILL;
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) c = I_ADDU;
        else if (fn == 6'b100011) c = I_SUBU;
`ifdef CTRL_JAL_EN
        else if (fn == 6'b001000) c = I_JR;
`endif
      end
      6'b001101: c = I_ORI;
      6'b100011: c = I_LW;
      6'b101011: c = I_SW;
      6'b000100: c = I_BEQ;
      6'b001111: c = I_LUI;
      6'b000010: c = I_J;
`ifdef CTRL_JAL_EN
      6'b000011: c = I_JAL;
`endif
      default:   c = I_ILL;
    endcase
    return c;
  endfunction

  // Control word for a given state and instruction class; registered one cycle ahead.
  function automatic ctl_t decode(input state_t st, input cls_t c);
    ctl_t o;
    o = '0;
    case (st)
      FETCH:  o.ir_wr = 1'b1;
      DECODE: begin
        if (c == I_ILL) begin
          o.illegal = 1'b1;
          o.pc_wr   = 1'b1;
        end
      end
      EXE, WB_ALU: begin
        case (c)
          I_ADDU: begin o.alu_op = 3'b000; o.reg_dst = 2'b01; end
          I_SUBU: begin o.alu_op = 3'b001; o.reg_dst = 2'b01; end
          I_ORI:  begin o.alu_src = 1'b1; o.ext_op = 2'b00; o.alu_op = 3'b010; end
          I_LUI:  begin o.alu_src = 1'b1; o.ext_op = 2'b10; o.alu_op = 3'b011; end
          default: o.alu_op = 3'b000;
        endcase
        if (st == WB_ALU) begin
          o.reg_wr = 1'b1;
          o.pc_wr  = 1'b1;
        end
      end
      MA, MR, MW, WB_MEM: begin
        o.alu_src = 1'b1;
        o.ext_op  = 2'b01;
        if (st == MW) begin
          o.mem_wr = 1'b1;
          o.pc_wr  = 1'b1;
        end
        if (st == WB_MEM) begin
          o.reg_wr     = 1'b1;
          o.mem_to_reg = 2'b01;
          o.pc_wr      = 1'b1;
        end
      end
      BR: begin
        o.alu_op = 3'b001;
        o.pc_wr  = 1'b1;
      end
      JMP: begin
        o.pc_wr   = 1'b1;
        o.npc_sel = (c == I_JR) ? 2'b11 : 2'b10;
        if (c == I_JAL) begin
          o.reg_wr     = 1'b1;
          o.reg_dst    = 2'b10;
          o.mem_to_reg = 2'b10;
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t      state_q, state_nxt;
  logic [5:0]  op_q, fn_q, op_nxt, fn_nxt;
  cls_t        cls;
  ctl_t        ctl_q;
  logic [31:0] cnt_q;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^bus.instr[25:6];

  // The opcode/funct seen here are the ones that will be latched, so the
  // registered control word for the next state is already correct.
  always_comb begin
    op_nxt = op_q;
    fn_nxt = fn_q;
    if (state_q == FETCH) begin
      op_nxt = bus.instr[31:26];
      fn_nxt = bus.instr[5:0];
    end
    cls       = classify(op_nxt, fn_nxt);
    state_nxt = FETCH;
    case (state_q)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (cls)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_nxt = EXE;
          I_LW, I_SW:                   state_nxt = MA;
          I_BEQ:                        state_nxt = BR;
          I_J, I_JAL, I_JR:             state_nxt = JMP;
          default:                      state_nxt = FETCH;
        endcase
      end
      EXE:     state_nxt = WB_ALU;
      MA:      state_nxt = (cls == I_LW) ? MR : MW;
      MR:      state_nxt = WB_MEM;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      ctl_q   <= decode(FETCH, I_ILL);
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      fn_q    <= fn_nxt;
      ctl_q   <= decode(state_nxt, cls);
      if (ctl_q.pc_wr) cnt_q <= cnt_q + 32'd1;
    end
  end

  // ir_wr is held low during reset even though the reset control word is FETCH's.
  assign bus.ir_wr      = ctl_q.ir_wr & ~reset;
  assign bus.pc_wr      = ctl_q.pc_wr;
  assign bus.npc_sel    = (state_q == BR) ? {1'b0, bus.zero} : ctl_q.npc_sel;
  assign bus.ext_op     = ctl_q.ext_op;
  assign bus.alu_src    = ctl_q.alu_src;
  assign bus.alu_op     = ctl_q.alu_op;
  assign bus.reg_dst    = ctl_q.reg_dst;
  assign bus.mem_to_reg = ctl_q.mem_to_reg;
  assign bus.reg_wr     = ctl_q.reg_wr;
  assign bus.mem_wr     = ctl_q.mem_wr;
  assign bus.illegal    = ctl_q.illegal;
  assign bus.state      = state_q;
  assign bus.instr_cnt  = cnt_q;

endmodule
